// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU results with FIFO-buffered long-latency results
// onto the single register-file write port, and tracks pending long-latency writes.
module wb_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_we,
    input  logic [4:0]  alu_waddr,
    input  logic [31:0] alu_wdata,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_waddr,
    input  logic [31:0] lsu_wdata,
    input  logic        iss_valid,
    input  logic [4:0]  iss_waddr,
    output logic        alu_stall,
    output logic        reg_we,
    output logic [4:0]  reg_waddr,
    output logic [31:0] reg_wdata,
    output logic [31:0] pend_vec,
    output logic        err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

    logic [4:0]    mem_addr_q [DEPTH];
    logic [31:0]   mem_data_q [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [31:0]   pend_q, pend_d;
    logic          err_q, err_d;
    logic          reg_we_q, reg_we_d;
    logic [4:0]    reg_waddr_q, reg_waddr_d;
    logic [31:0]   reg_wdata_q, reg_wdata_d;

    logic          push, pop, fifo_ne, stall, sel_we;
    logic [4:0]    sel_addr;
    logic [31:0]   sel_data;

    always_comb begin
        fifo_ne  = (count_q != '0);
        stall    = (starve_q == STARVE_C);
        push     = lsu_valid && (count_q < DEPTH_C);
        pop      = 1'b0;
        sel_we   = 1'b0;
        sel_addr = alu_waddr;
        sel_data = alu_wdata;

        // A starved FIFO beats the ALU; an ALU write during stall is dropped.
        if (stall && fifo_ne) begin
            pop = 1'b1;
        end else if (alu_we && !stall) begin
            sel_we = 1'b1;
        end else if (fifo_ne) begin
            pop = 1'b1;
        end

        if (pop) begin
            sel_we   = 1'b1;
            sel_addr = mem_addr_q[head_q];
            sel_data = mem_data_q[head_q];
        end

        head_d  = pop  ? head_q + PW'(1) : head_q;
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (!fifo_ne || pop) begin
            starve_d = '0;
        end else if (starve_q != STARVE_C) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end

        // Clear first so a same-cycle issue to the same register wins.
        pend_d = pend_q;
        if (pop && sel_addr != 5'd0) pend_d[sel_addr] = 1'b0;
        if (iss_valid && iss_waddr != 5'd0) pend_d[iss_waddr] = 1'b1;

        err_d = err_q | (alu_we && stall);

        reg_we_d    = sel_we && (sel_addr != 5'd0);
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;
        if (reg_we_d) begin
            reg_waddr_d = sel_addr;
            reg_wdata_d = sel_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            pend_q      <= '0;
            err_q       <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            pend_q      <= pend_d;
            err_q       <= err_d;
            reg_we_q    <= reg_we_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_addr_q[tail_q] <= lsu_waddr;
            mem_data_q[tail_q] <= lsu_wdata;
        end
    end

    assign lsu_ready = (count_q < DEPTH_C);
    assign alu_stall = stall;
    assign reg_we    = reg_we_q;
    assign reg_waddr = reg_waddr_q;
    assign reg_wdata = reg_wdata_q;
    assign pend_vec  = pend_q;
    assign err       = err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized scoreboard bench for wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;
    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_we = 1'b0;
    logic [4:0]  alu_waddr = '0;
    logic [31:0] alu_wdata = '0;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [4:0]  lsu_waddr = '0;
    logic [31:0] lsu_wdata = '0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_waddr = '0;
    logic        alu_stall;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic [31:0] pend_vec;
    logic        err;

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .alu_we(alu_we), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
        .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata),
        .iss_valid(iss_valid), .iss_waddr(iss_waddr),
        .alu_stall(alu_stall),
        .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .pend_vec(pend_vec), .err(err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state.
    wr_t         mq[$];
    wr_t         exp_q[$];
    wr_t         src_q[$];
    int          starve = 0;
    logic [31:0] pend = '0;
    logic        m_err = 1'b0;
    logic        m_we = 1'b0;
    logic        m_in_rst = 1'b0;
    logic        started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        wr_t e;
        bit  stl, popped, wr;
        int  size;
        if (rst) begin
            mq.delete();
            exp_q.delete();
            starve   = 0;
            pend     = '0;
            m_err    = 1'b0;
            m_we     = 1'b0;
            m_in_rst = 1'b1;
            started  = 1'b1;
        end else begin
            m_in_rst = 1'b0;
            stl      = (starve == STARVE_MAX);
            size     = mq.size();
            popped   = 0;
            wr       = 0;
            e        = '0;
            if (stl && size > 0) begin
                e = mq.pop_front(); popped = 1; wr = 1;
            end else if (alu_we && !stl) begin
                e = '{a: alu_waddr, d: alu_wdata}; wr = 1;
            end else if (size > 0) begin
                e = mq.pop_front(); popped = 1; wr = 1;
            end
            if (alu_we && stl) m_err = 1'b1;
            if (lsu_valid && size < DEPTH) mq.push_back('{a: lsu_waddr, d: lsu_wdata});
            if (size == 0 || popped) starve = 0;
            else if (starve < STARVE_MAX) starve = starve + 1;
            if (popped && e.a != 5'd0) pend[e.a] = 1'b0;
            if (iss_valid && iss_waddr != 5'd0) pend[iss_waddr] = 1'b1;
            m_we = wr && (e.a != 5'd0);
            if (m_we) exp_q.push_back(e);
        end
    end

    always @(negedge clk) begin
        wr_t e;
        if (started) begin
            chk("reg_we", {31'd0, reg_we}, {31'd0, m_we});
            if (reg_we === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got r%0d=0x%08h expected none", reg_waddr, reg_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (reg_waddr !== e.a || reg_wdata !== e.d) begin
                        errors++;
                        $display("FAIL write_data: got r%0d=0x%08h expected r%0d=0x%08h",
                                 reg_waddr, reg_wdata, e.a, e.d);
                    end
                end
            end
            chk("pend_vec", pend_vec, pend);
            chk("lsu_ready", {31'd0, lsu_ready}, {31'd0, mq.size() < DEPTH});
            chk("alu_stall", {31'd0, alu_stall}, {31'd0, starve == STARVE_MAX});
            chk("err", {31'd0, err}, {31'd0, m_err});
            if (m_in_rst) begin
                chk("rst_waddr", {27'd0, reg_waddr}, 32'd0);
                chk("rst_wdata", reg_wdata, 32'd0);
            end
        end
    end

    // One cycle of stimulus; the LSU source holds its head entry until accepted.
    task automatic step(input logic a_we, input logic [4:0] a_addr, input logic [31:0] a_data,
                        input logic i_v, input logic [4:0] i_a, input logic r, input logic obey);
        logic rdy;
        wr_t  tmp;
        rst       = r;
        alu_we    = obey ? (a_we && !alu_stall) : a_we;
        alu_waddr = a_addr;
        alu_wdata = a_data;
        iss_valid = i_v;
        iss_waddr = i_a;
        lsu_valid = (src_q.size() > 0);
        if (lsu_valid) begin
            lsu_waddr = src_q[0].a;
            lsu_wdata = src_q[0].d;
        end
        rdy = lsu_ready;
        @(posedge clk);
        if (lsu_valid && rdy && !r) tmp = src_q.pop_front();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    endtask

    initial begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b1);

        // ALU only
        step(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 1'b0, 1'b1);
        chk("alu_r5_we", {31'd0, reg_we}, 32'd1);
        chk("alu_r5_addr", {27'd0, reg_waddr}, 32'd5);
        chk("alu_r5_data", reg_wdata, 32'h1234);
        idle(2);

        // Collision
        src_q.push_back('{a: 5'd4, d: 32'hBBBB});
        step(1'b1, 5'd3, 32'hAAAA, 1'b0, 5'd0, 1'b0, 1'b1);
        chk("coll_first", {27'd0, reg_waddr}, 32'd3);
        idle(1);
        chk("coll_second", reg_wdata, 32'hBBBB);
        idle(2);

        // Full / backpressure with ALU held busy
        for (int i = 0; i < 3; i++) src_q.push_back('{a: 5'(10 + i), d: 32'hC000 + i});
        for (int i = 0; i < 16; i++) step(1'b1, 5'(1 + i % 3), $urandom, 1'b0, 5'd0, 1'b0, 1'b1);
        idle(4);

        // Scoreboard set/clear and set-wins
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 1'b1);
        chk("pend7_set", pend_vec, 32'h80);
        src_q.push_back('{a: 5'd7, d: 32'h55});
        idle(2);
        chk("pend7_clr", pend_vec, 32'h0);
        src_q.push_back('{a: 5'd7, d: 32'h66});
        idle(1);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 1'b1);
        chk("pend7_setwins", pend_vec, 32'h80);
        src_q.push_back('{a: 5'd7, d: 32'h77});
        idle(3);

        // r0 handling
        src_q.push_back('{a: 5'd0, d: 32'hBEEF});
        step(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 1'b0, 1'b1);
        idle(3);

        // Reset mid-run with two buffered entries
        src_q.push_back('{a: 5'd4, d: 32'h44});
        src_q.push_back('{a: 5'd7, d: 32'h77});
        step(1'b1, 5'd1, 32'h11, 1'b1, 5'd4, 1'b0, 1'b1);
        step(1'b1, 5'd2, 32'h22, 1'b1, 5'd7, 1'b0, 1'b1);
        step(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 1'b0, 1'b1);
        chk("pre_rst_pend", pend_vec, 32'h90);
        chk("pre_rst_full", {31'd0, lsu_ready}, 32'd0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        chk("rst_pend", pend_vec, 32'h0);
        chk("rst_ready", {31'd0, lsu_ready}, 32'd1);
        chk("rst_we", {31'd0, reg_we}, 32'd0);
        idle(10);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (src_q.size() == 0 && $urandom_range(0, 2) == 0)
                src_q.push_back('{a: 5'($urandom_range(0, 7)), d: $urandom});
            step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 127) == 0), 1'b1);
        end
        idle(12);

        // Protocol violation: ALU keeps writing through the stall
        src_q.push_back('{a: 5'd9, d: 32'h99});
        for (int i = 0; i < 10; i++) step(1'b1, 5'd2, $urandom, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("err_sticky", {31'd0, err}, 32'd1);
        idle(3);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d writes outstanding expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter in front of the MIPS register file's single write port. Merges the single-cycle ALU result stream with buffered long-latency results (loads, mul/div), using a small FIFO and a starvation guard. Presents at most one write per cycle on the register file's ena/waddr/wdata port. Keeps a pending-write scoreboard that issue logic reads to stall on outstanding long-latency destinations.

## Interface
- DEPTH, 2, long-latency result FIFO entries (power of two, ≥2)
- STARVE_MAX, 4, cycles a non-empty FIFO may lose arbitration before ALU stall is forced (≥1)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- alu_we  in  1  ALU result valid this cycle
- alu_waddr  in  5  ALU destination register
- alu_wdata  in  32  ALU result
- lsu_valid  in  1  long-latency result offered
- lsu_ready  out  1  FIFO can accept; equals count < DEPTH
- lsu_waddr  in  5  long-latency destination
- lsu_wdata  in  32  long-latency result
- iss_valid  in  1  long-latency op issued this cycle
- iss_waddr  in  5  its destination register
- alu_stall  out  1  upstream must hold alu_we low while high
- reg_we  out  1  register file write enable (ena_i)
- reg_waddr  out  5  register file waddr
- reg_wdata  out  32  register file wdata
- pend_vec  out  32  bit n set: long-latency write to rn outstanding
- err  out  1  sticky: alu_we seen while alu_stall high

## Operation
- LSU push: lsu_valid && lsu_ready. Entry {waddr, wdata} is written at the tail. No push when full; lsu_valid is ignored then.
- Arbitration, each cycle, in priority order:
  - If alu_stall=1 and FIFO non-empty: pop the head and write it.
  - Else if alu_we=1: write the ALU result.
  - Else if FIFO non-empty: pop the head and write it.
  - Else: no write.
- A push and a pop in the same cycle are legal. Count is unchanged. An entry pushed this cycle is not poppable until the next cycle.
- Writes with destination 0 are consumed normally, but reg_we stays 0 for them. A popped r0 entry still clears nothing in pend_vec.
- Starvation counter: 0 when the FIFO is empty or a pop occurs. Otherwise it increments, saturating at STARVE_MAX.
- alu_stall = (counter == STARVE_MAX), decoded from the registered counter.
- Scoreboard:
  - iss_valid sets pend_vec[iss_waddr], except for r0.
  - A FIFO pop to address a clears that bit.
  - Set and clear of the same bit in the same cycle: set wins.
- err sets when alu_we && alu_stall. It clears only on reset. In that cycle the ALU write is dropped.
- FIFO pointers wrap modulo DEPTH. Order is strict FIFO.

## Timing
- reg_we, reg_waddr and reg_wdata are registered. A write selected in cycle t appears in cycle t+1. The register file commits it at the edge ending t+1.
- lsu_ready depends only on registered count, with no combinational path from lsu_valid.
- pend_vec updates one cycle after the iss_valid or pop edge.
- alu_stall rises the cycle after the counter reaches STARVE_MAX. It falls the cycle after the forced pop.
- Reset, for whole cycles with rst=1:
  - reg_we=0, reg_waddr=0, reg_wdata=0, pend_vec=0, alu_stall=0, err=0.
  - FIFO empty, so lsu_ready=1. Counter=0.
- Reset mid-operation discards buffered entries and pending bits without writing them.

## Test plan
- ALU only: alu_we=1, r5←0x1234 → reg_we=1, waddr=5, wdata=0x1234 one cycle later. FIFO stays empty and lsu_ready=1.
- Collision:
  - Stimulus: r3←0xAAAA from ALU and r4←0xBBBB from LSU in the same cycle, then alu_we=0.
  - Response: ALU write appears first. r4←0xBBBB follows the next cycle.
- Full/backpressure:
  - Stimulus: hold alu_we=1 and push 3 LSU results with DEPTH=2.
  - Response: lsu_ready drops after 2 pushes; the third is held by the source.
  - Response: with STARVE_MAX=4, alu_stall rises; forced pops then drain the entries in order.
- Scoreboard: iss_valid r7, later pop of r7←0x55 → pend_vec[7] goes 0→1→0. Issue r7 coincident with a pop of r7 → bit stays 1.
- r0 handling: ALU and LSU writes to r0 → reg_we never 1 and pend_vec[0] always 0.
- Reset mid-run: assert rst with 2 buffered entries and pend_vec=0x0000_0090. Next cycle: all outputs 0, lsu_ready=1, and no buffered write appears after rst falls.
